// File: rtl/fb_rd_line_sched.sv
// Frame-buffer line-read scheduler: one burst read per video line, then one line of unpacker pixel enables.
// Optional double buffering is enabled by defining FB_RD_DOUBLE_BUF_EN (adds port wr_buf_i).
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_IDLE   | frame finished or never started; waiting for frame_start_i
// ST_ARMED  | ready for the next line; waiting for line_req_i
// ST_CMD    | burst read command presented, waiting for cmd_ready_i
// ST_FILL   | command accepted, waiting for a full line in the read FIFO
// ST_STREAM | dma_de_24b_o high for H_ACTIVE cycles
module fb_rd_line_sched #(
    parameter int H_ACTIVE    = 1280,
    parameter int V_ACTIVE    = 720,
    parameter int ADDR_W      = 28,
    parameter int BASE_ADDR   = 0,
    parameter int LINE_STRIDE = 4096,
    parameter int FRAME_SIZE  = 4194304,
    parameter int LVL_W       = 11
) (
    input  logic              sys_clk,
    input  logic              rst,
`ifdef FB_RD_DOUBLE_BUF_EN
    input  logic              wr_buf_i,
`endif
    input  logic              frame_start_i,
    input  logic              line_req_i,
    output logic              cmd_valid_o,
    input  logic              cmd_ready_i,
    output logic [ADDR_W-1:0] cmd_addr_o,
    output logic [15:0]       cmd_len_o,
    input  logic [LVL_W-1:0]  fifo_level_i,
    output logic              dma_rst_o,
    output logic              dma_de_24b_o,
    output logic              line_done_o,
    output logic              frame_done_o,
    output logic              underrun_o
);

    localparam int LINE_W = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
    localparam int PIX_W  = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;

    localparam logic [15:0]       BURST_LEN = 16'(H_ACTIVE * 3 / 4);
    localparam logic [PIX_W-1:0]  PIX_LAST  = PIX_W'(H_ACTIVE - 1);
    localparam logic [LINE_W-1:0] LINE_LAST = LINE_W'(V_ACTIVE - 1);

    // Buffers must not overlap and a line of 24b pixels must fit its stride.
    if ((H_ACTIVE % 4) != 0 || LINE_STRIDE < H_ACTIVE * 3 ||
        FRAME_SIZE < LINE_STRIDE * V_ACTIVE) begin : g_param_err
        $error("fb_rd_line_sched: inconsistent geometry parameters");
    end

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARMED,
        ST_CMD,
        ST_FILL,
        ST_STREAM
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [LINE_W-1:0] line_cnt_q;
    logic [PIX_W-1:0]  pix_cnt_q;
    logic [ADDR_W-1:0] frame_base;
    logic [ADDR_W-1:0] line_addr;
    logic              load_cmd;
    logic              start_line;
    logic              last_pix;
    logic              req_lost;
    logic              last_line;
    logic              level_ok;

`ifdef FB_RD_DOUBLE_BUF_EN
    logic buf_sel_q;

    // Read the buffer the writer is not filling; held for the whole frame.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            buf_sel_q <= 1'b0;
        end else if (frame_start_i) begin
            buf_sel_q <= ~wr_buf_i;
        end
    end

    assign frame_base = ADDR_W'(BASE_ADDR) + (buf_sel_q ? ADDR_W'(FRAME_SIZE) : '0);
`else
    assign frame_base = ADDR_W'(BASE_ADDR);
`endif

    assign line_addr = frame_base + ADDR_W'(line_cnt_q) * ADDR_W'(LINE_STRIDE);
    assign last_line = (line_cnt_q == LINE_LAST);
    assign level_ok  = ({16'b0, fifo_level_i} >= {{LVL_W{1'b0}}, cmd_len_o});

    assign cmd_valid_o  = (state_q == ST_CMD);
    assign dma_de_24b_o = (state_q == ST_STREAM);

    always_comb begin
        state_d    = state_q;
        load_cmd   = 1'b0;
        start_line = 1'b0;
        last_pix   = 1'b0;
        req_lost   = 1'b0;
        if (frame_start_i) begin
            state_d = ST_ARMED;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_IDLE;
                end
                ST_ARMED: begin
                    if (line_req_i) begin
                        state_d  = ST_CMD;
                        load_cmd = 1'b1;
                    end
                end
                ST_CMD: begin
                    req_lost = line_req_i;
                    if (cmd_ready_i) begin
                        state_d = ST_FILL;
                    end
                end
                ST_FILL: begin
                    req_lost = line_req_i;
                    if (level_ok) begin
                        state_d    = ST_STREAM;
                        start_line = 1'b1;
                    end
                end
                ST_STREAM: begin
                    req_lost = line_req_i;
                    if (pix_cnt_q == '0) begin
                        last_pix = 1'b1;
                        state_d  = last_line ? ST_IDLE : ST_ARMED;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            line_cnt_q   <= '0;
            pix_cnt_q    <= '0;
            cmd_addr_o   <= '0;
            cmd_len_o    <= '0;
            dma_rst_o    <= 1'b0;
            line_done_o  <= 1'b0;
            frame_done_o <= 1'b0;
            underrun_o   <= 1'b0;
        end else begin
            state_q      <= state_d;
            dma_rst_o    <= frame_start_i;
            line_done_o  <= last_pix;
            frame_done_o <= last_pix && last_line;

            if (frame_start_i) begin
                underrun_o <= 1'b0;
            end else if (req_lost) begin
                underrun_o <= 1'b1;
            end

            if (frame_start_i) begin
                line_cnt_q <= '0;
            end else if (last_pix) begin
                line_cnt_q <= last_line ? '0 : line_cnt_q + 1'b1;
            end

            if (load_cmd) begin
                cmd_addr_o <= line_addr;
                cmd_len_o  <= BURST_LEN;
            end

            // Pixel timer counts down to the last pixel of the line.
            if (start_line) begin
                pix_cnt_q <= PIX_LAST;
            end else if (state_q == ST_STREAM && pix_cnt_q != '0) begin
                pix_cnt_q <= pix_cnt_q - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fb_rd_line_sched.sv
// Directed bench for fb_rd_line_sched with a cycle-level reference model and literal spot checks.
module tb_fb_rd_line_sched;

    localparam int H      = 16;
    localparam int V      = 3;
    localparam int AW     = 16;
    localparam int BASE   = 'hFFC0;
    localparam int STRIDE = 64;
    localparam int FSZ    = 4096;
    localparam int LW     = 11;
    localparam int LEN    = H * 3 / 4;

`ifdef FB_RD_DOUBLE_BUF_EN
    localparam logic [31:0] EXP_A0 = 32'h0FC0;
    localparam logic [31:0] EXP_A1 = 32'h1000;
    localparam logic [31:0] EXP_A2 = 32'h1040;
`else
    localparam logic [31:0] EXP_A0 = 32'hFFC0;
    localparam logic [31:0] EXP_A1 = 32'h0000;
    localparam logic [31:0] EXP_A2 = 32'h0040;
`endif
    localparam logic [31:0] EXP_B0 = 32'hFFC0;

    logic          sys_clk = 1'b0;
    logic          rst = 1'b0;
    logic          frame_start_i = 1'b0;
    logic          line_req_i = 1'b0;
    logic          cmd_ready_i = 1'b0;
    logic          wr_buf_i = 1'b0;
    logic [LW-1:0] fifo_level_i = '0;
    logic          cmd_valid_o;
    logic [AW-1:0] cmd_addr_o;
    logic [15:0]   cmd_len_o;
    logic          dma_rst_o;
    logic          dma_de_24b_o;
    logic          line_done_o;
    logic          frame_done_o;
    logic          underrun_o;

    int n_checks = 0;
    int n_err = 0;

    fb_rd_line_sched #(
        .H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW), .BASE_ADDR(BASE),
        .LINE_STRIDE(STRIDE), .FRAME_SIZE(FSZ), .LVL_W(LW)
    ) dut (
        .sys_clk(sys_clk),
        .rst(rst),
`ifdef FB_RD_DOUBLE_BUF_EN
        .wr_buf_i(wr_buf_i),
`endif
        .frame_start_i(frame_start_i),
        .line_req_i(line_req_i),
        .cmd_valid_o(cmd_valid_o),
        .cmd_ready_i(cmd_ready_i),
        .cmd_addr_o(cmd_addr_o),
        .cmd_len_o(cmd_len_o),
        .fifo_level_i(fifo_level_i),
        .dma_rst_o(dma_rst_o),
        .dma_de_24b_o(dma_de_24b_o),
        .line_done_o(line_done_o),
        .frame_done_o(frame_done_o),
        .underrun_o(underrun_o)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: phases of a line read, pixels remaining, and pending pulses.
    localparam int P_IDLE = 0, P_WAIT_REQ = 1, P_CMD = 2, P_FILL = 3, P_STREAM = 4;
    int          m_phase = P_IDLE;
    int          m_line = 0;
    int          m_left = 0;
    longint      m_addr = 0;
    int          m_len = 0;
    int          m_sel = 0;
    logic        m_unr = 1'b0;
    logic        m_rst = 1'b0;
    logic        m_ld = 1'b0;
    logic        m_fd = 1'b0;

    function automatic longint frame_base(input int sel);
`ifdef FB_RD_DOUBLE_BUF_EN
        return longint'(BASE) + longint'(sel) * FSZ;
`else
        return longint'(BASE) + 0 * sel;
`endif
    endfunction

    always @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            m_phase = P_IDLE; m_line = 0; m_left = 0; m_addr = 0; m_len = 0;
            m_sel = 0; m_unr = 0; m_rst = 0; m_ld = 0; m_fd = 0;
        end else begin
            m_rst = 0; m_ld = 0; m_fd = 0;
            if (frame_start_i) begin
                m_rst = 1; m_line = 0; m_unr = 0; m_sel = wr_buf_i ? 0 : 1;
                m_phase = P_WAIT_REQ;
            end else begin
                if (line_req_i && m_phase inside {P_CMD, P_FILL, P_STREAM}) m_unr = 1;
                case (m_phase)
                    P_WAIT_REQ: if (line_req_i) begin
                        m_addr = (frame_base(m_sel) + longint'(m_line) * STRIDE) % (longint'(1) << AW);
                        m_len = LEN;
                        m_phase = P_CMD;
                    end
                    P_CMD: if (cmd_ready_i) m_phase = P_FILL;
                    P_FILL: if (int'(fifo_level_i) >= m_len) begin
                        m_phase = P_STREAM;
                        m_left = H;
                    end
                    P_STREAM: begin
                        m_left--;
                        if (m_left == 0) begin
                            m_ld = 1;
                            if (m_line == V - 1) begin
                                m_line = 0; m_fd = 1; m_phase = P_IDLE;
                            end else begin
                                m_line++; m_phase = P_WAIT_REQ;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always @(negedge sys_clk) begin
        check("m_cmd_valid", 32'(cmd_valid_o), 32'(m_phase == P_CMD));
        check("m_dma_de", 32'(dma_de_24b_o), 32'(m_phase == P_STREAM));
        check("m_dma_rst", 32'(dma_rst_o), 32'(m_rst));
        check("m_line_done", 32'(line_done_o), 32'(m_ld));
        check("m_frame_done", 32'(frame_done_o), 32'(m_fd));
        check("m_underrun", 32'(underrun_o), 32'(m_unr));
        check("m_cmd_addr", 32'(cmd_addr_o), 32'(m_addr));
        check("m_cmd_len", 32'(cmd_len_o), 32'(m_len));
    end

    task automatic pulse_fs();
        @(negedge sys_clk); frame_start_i = 1'b1;
        @(negedge sys_clk); frame_start_i = 1'b0;
    endtask

    task automatic pulse_req();
        @(negedge sys_clk); line_req_i = 1'b1;
        @(negedge sys_clk); line_req_i = 1'b0;
    endtask

    task automatic stream_line(output int de_cnt, output logic ld, output logic fd);
        de_cnt = 0; ld = 1'b0; fd = 1'b0;
        for (int i = 0; i < 200 && !ld; i++) begin
            @(negedge sys_clk);
            if (dma_de_24b_o) de_cnt++;
            if (line_done_o) begin
                ld = 1'b1;
                fd = frame_done_o;
            end
        end
    endtask

    task automatic wait_de(output logic seen);
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge sys_clk);
            seen = dma_de_24b_o;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   de_cnt;
        logic ld, fd, seen;

        #1 rst = 1'b1;
        repeat (3) @(negedge sys_clk);
        rst = 1'b0;
        @(negedge sys_clk);
        check("reset_addr", 32'(cmd_addr_o), 32'h0);
        check("reset_valid", 32'(cmd_valid_o), 32'h0);
        check("reset_len", 32'(cmd_len_o), 32'h0);

        pulse_req();
        check("idle_req_ignored", 32'(cmd_valid_o), 32'h0);

        pulse_fs();
        check("fs_dma_rst_hi", 32'(dma_rst_o), 32'h1);
        @(negedge sys_clk);
        check("fs_dma_rst_lo", 32'(dma_rst_o), 32'h0);

        // Line 0: ready and level already satisfied.
        fifo_level_i = LW'(LEN);
        cmd_ready_i = 1'b1;
        pulse_req();
        check("l0_valid", 32'(cmd_valid_o), 32'h1);
        check("l0_addr", 32'(cmd_addr_o), EXP_A0);
        check("l0_len", 32'(cmd_len_o), 32'd12);
        stream_line(de_cnt, ld, fd);
        check("l0_done_seen", 32'(ld), 32'h1);
        check("l0_de_count", 32'(de_cnt), 32'd16);

        // Line 1: controller stalls, then FIFO fills slowly.
        cmd_ready_i = 1'b0;
        fifo_level_i = '0;
        pulse_req();
        for (int i = 0; i < 5; i++) begin
            @(negedge sys_clk);
            check("l1_stall_valid", 32'(cmd_valid_o), 32'h1);
            check("l1_stall_addr", 32'(cmd_addr_o), EXP_A1);
            check("l1_stall_de", 32'(dma_de_24b_o), 32'h0);
        end
        cmd_ready_i = 1'b1;
        @(negedge sys_clk);
        cmd_ready_i = 1'b0;
        repeat (3) @(negedge sys_clk);
        fifo_level_i = LW'(LEN - 1);
        repeat (2) @(negedge sys_clk);
        check("l1_below_len_de", 32'(dma_de_24b_o), 32'h0);
        fifo_level_i = LW'(LEN);
        stream_line(de_cnt, ld, fd);
        check("l1_done_seen", 32'(ld), 32'h1);
        check("l1_de_count", 32'(de_cnt), 32'd16);

        // Line 2 (last) with an overlapping request during streaming.
        cmd_ready_i = 1'b1;
        pulse_req();
        check("l2_addr", 32'(cmd_addr_o), EXP_A2);
        wait_de(seen);
        check("l2_de_seen", 32'(seen), 32'h1);
        repeat (4) @(negedge sys_clk);
        pulse_req();
        check("l2_underrun", 32'(underrun_o), 32'h1);
        stream_line(de_cnt, ld, fd);
        check("l2_done_seen", 32'(ld), 32'h1);
        check("l2_frame_done", 32'(fd), 32'h1);
        @(negedge sys_clk);
        check("l2_underrun_sticky", 32'(underrun_o), 32'h1);
        pulse_req();
        check("post_frame_idle", 32'(cmd_valid_o), 32'h0);

        // Frame 2: other buffer, then abort mid-line.
        wr_buf_i = 1'b1;
        pulse_fs();
        check("f2_underrun_clr", 32'(underrun_o), 32'h0);
        pulse_req();
        check("f2_addr", 32'(cmd_addr_o), EXP_B0);
        wait_de(seen);
        check("f2_de_seen", 32'(seen), 32'h1);
        repeat (3) @(negedge sys_clk);
        pulse_fs();
        check("abort_de_drop", 32'(dma_de_24b_o), 32'h0);
        check("abort_dma_rst", 32'(dma_rst_o), 32'h1);

        // Simultaneous frame start and line request: frame start wins.
        @(negedge sys_clk);
        frame_start_i = 1'b1; line_req_i = 1'b1;
        @(negedge sys_clk);
        frame_start_i = 1'b0; line_req_i = 1'b0;
        check("simul_valid", 32'(cmd_valid_o), 32'h0);
        check("simul_dma_rst", 32'(dma_rst_o), 32'h1);

        pulse_req();
        check("restart_addr", 32'(cmd_addr_o), EXP_B0);
        stream_line(de_cnt, ld, fd);
        check("restart_done_seen", 32'(ld), 32'h1);
        check("restart_de_count", 32'(de_cnt), 32'd16);
        check("restart_no_fd", 32'(fd), 32'h0);

        repeat (4) @(negedge sys_clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
